// File: rtl/pacman_key_queue_pkg.sv
// Shared types for the player keyboard front end: direction codes, key codes,
// handshake states and the key decoder.
package pacman_key_queue_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    localparam logic [7:0] KEY_UP    = 8'hf7;
    localparam logic [7:0] KEY_DOWN  = 8'hf3;
    localparam logic [7:0] KEY_LEFT  = 8'he1;
    localparam logic [7:0] KEY_RIGHT = 8'he4;

    typedef enum logic [1:0] {
        HS_IDLE     = 2'd0,
        HS_ACK      = 2'd1,
        HS_WAIT_REL = 2'd2
    } hs_state_e;

    typedef struct packed {
        logic valid;
        dir_e dir;
    } key_dec_t;

    function automatic key_dec_t decode_key(input logic [7:0] code);
        key_dec_t d;
        d.valid = 1'b1;
        d.dir   = DIR_UP;
        case (code)
            KEY_UP:    d.dir = DIR_UP;
            KEY_DOWN:  d.dir = DIR_DOWN;
            KEY_LEFT:  d.dir = DIR_LEFT;
            KEY_RIGHT: d.dir = DIR_RIGHT;
            default:   d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/pacman_key_queue_if.sv
// Keyboard / CPU side signals of the player key queue.
interface pacman_key_queue_if #(parameter int DEPTH = 4);
    logic [7:0]              keycode;
    logic                    keystrobe;
    logic                    frame_tick;
    logic                    consume;
    logic [1:0]              dir_out;
    logic                    dir_pending;
    logic [$clog2(DEPTH):0]  count;
    logic                    overflow;

    modport master (
        output keycode, frame_tick, consume,
        input  keystrobe, dir_out, dir_pending, count, overflow
    );

    modport slave (
        input  keycode, frame_tick, consume,
        output keystrobe, dir_out, dir_pending, count, overflow
    );
endinterface

// File: rtl/pacman_key_queue_dir_fifo.sv
// DEPTH x 2-bit turn queue: push, pop, overwrite-tail and head/tail peek.
// The caller never requests overwrite together with pop.
module dir_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    overwrite,
    input  logic                    pop,
    input  logic [1:0]              din,
    output logic [1:0]              head,
    output logic [1:0]              tail,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);

    logic [1:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] tail_ptr;
    logic          advance;

    assign tail_ptr = wr_ptr - PW'(1);
    assign advance  = push && !overwrite;
    assign head     = mem[rd_ptr];
    assign tail     = mem[tail_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (advance)
                wr_ptr <= wr_ptr + PW'(1);
            count <= count + (PW+1)'(advance) - (PW+1)'(pop);
        end
    end

    // NOTE: storage is not reset; entries are only read while count says they are live.
    always_ff @(posedge clk) begin
        if (push)
            mem[overwrite ? tail_ptr : wr_ptr] <= din;
    end

endmodule

// File: rtl/pacman_key_queue.sv
// Player keyboard front end: keycode handshake, direction decode, turn queue
// with per-frame expiry, and the desired rotation fed to playerRot.
module pacman_key_queue
    import pacman_key_queue_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int EXPIRE_FRAMES = 8
) (
    input  logic               clk,
    input  logic               reset,
    pacman_key_queue_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    hs_state_e       state;
    key_dec_t        dec;
    dir_e            last_dir;
    logic [7:0]      age;
    logic [1:0]      fifo_head;
    logic [1:0]      fifo_tail;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   post_count;
    logic            empty;
    logic            key_push;
    logic            expire;
    logic            pop;
    logic            dup;
    logic            push_ok;
    logic            overwrite;

    assign dec      = decode_key(bus.keycode);
    assign empty    = (fifo_count == '0);
    assign key_push = (state == HS_IDLE) && bus.keycode[7] && dec.valid;
    assign expire   = bus.frame_tick && !empty && (age == 8'(EXPIRE_FRAMES - 1));
    assign pop      = (bus.consume || expire) && !empty;

    // Duplicate and full checks look at the queue as it stands after this cycle's pop.
    assign post_count = fifo_count - CW'(pop);
    assign dup        = (post_count != '0) && (dec.dir == fifo_tail);
    assign push_ok    = key_push && !dup;
    assign overwrite  = push_ok && (post_count == CW'(DEPTH));

    dir_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_ok),
        .overwrite (overwrite),
        .pop       (pop),
        .din       (dec.dir),
        .head      (fifo_head),
        .tail      (fifo_tail),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= HS_IDLE;
            bus.keystrobe <= 1'b0;
        end else begin
            case (state)
                HS_IDLE: if (bus.keycode[7]) begin
                    state         <= HS_ACK;
                    bus.keystrobe <= 1'b1;
                end
                HS_ACK: begin
                    state         <= HS_WAIT_REL;
                    bus.keystrobe <= 1'b0;
                end
                HS_WAIT_REL: if (!bus.keycode[7])
                    state <= HS_IDLE;
                default: begin
                    state         <= HS_IDLE;
                    bus.keystrobe <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_dir     <= DIR_LEFT;
            age          <= '0;
            bus.overflow <= 1'b0;
        end else begin
            // Expiry drops the head silently; only a CPU consume records it.
            if (bus.consume && !empty)
                last_dir <= dir_e'(fifo_head);
            if (pop || empty)
                age <= '0;
            else if (bus.frame_tick)
                age <= age + 8'd1;
            if (overwrite)
                bus.overflow <= 1'b1;
        end
    end

    assign bus.count       = fifo_count;
    assign bus.dir_pending = !empty;
    assign bus.dir_out     = empty ? last_dir : fifo_head;

endmodule

// File: tb/tb_pacman_key_queue.sv
// Directed bench for pacman_key_queue: handshake, duplicate drop, overflow,
// expiry, simultaneous pop/push and reset during acknowledge.
module tb_pacman_key_queue;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   strobes;

    always #5 clk = ~clk;

    pacman_key_queue_if #(.DEPTH(4)) bus ();

    pacman_key_queue #(.DEPTH(4), .EXPIRE_FRAMES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] code);
        bus.keycode = code;
        tick();
        tick();
        bus.keycode = 8'h00;
        tick();
    endtask

    task automatic frame();
        bus.frame_tick = 1'b1;
        tick();
        bus.frame_tick = 1'b0;
    endtask

    task automatic take();
        bus.consume = 1'b1;
        tick();
        bus.consume = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        bus.keycode    = 8'h00;
        bus.frame_tick = 1'b0;
        bus.consume    = 1'b0;
        tick();
        tick();
        check("rst_keystrobe", bus.keystrobe, 0);
        check("rst_count", bus.count, 0);
        check("rst_dir_out", bus.dir_out, 1);
        check("rst_pending", bus.dir_pending, 0);
        check("rst_overflow", bus.overflow, 0);
        reset = 1'b1;
        tick();

        // Held right key: one strobe in N+1, queue updated in N+1.
        bus.keycode = 8'he4;
        tick();
        check("hold_strobe_n1", bus.keystrobe, 1);
        check("hold_dir_out", bus.dir_out, 3);
        check("hold_count", bus.count, 1);
        strobes = 1;
        repeat (9) begin
            tick();
            strobes += int'(bus.keystrobe);
        end
        check("hold_strobe_once", 8'(strobes), 1);
        bus.keycode = 8'h00;
        tick();
        press(8'he4);
        check("dup_count", bus.count, 1);
        check("dup_dir_out", bus.dir_out, 3);

        // Fill to overflow: 0,1,2,3 then 0 overwrites the tail.
        do_reset();
        press(8'hf7);
        press(8'he1);
        press(8'hf3);
        press(8'he4);
        check("full_count", bus.count, 4);
        check("full_no_ovf", bus.overflow, 0);
        press(8'hf7);
        check("ovf_count", bus.count, 4);
        check("ovf_flag", bus.overflow, 1);
        check("drain_head0", bus.dir_out, 0);
        take();
        check("drain_head1", bus.dir_out, 1);
        take();
        check("drain_head2", bus.dir_out, 2);
        take();
        check("drain_head3", bus.dir_out, 0);
        take();
        check("drain_last_dir", bus.dir_out, 0);
        check("drain_pending", bus.dir_pending, 0);

        // Non-direction key: acknowledged once, nothing queued.
        bus.keycode = 8'h85;
        strobes = 0;
        repeat (4) begin
            tick();
            strobes += int'(bus.keystrobe);
        end
        check("nondir_strobe", 8'(strobes), 1);
        check("nondir_count", bus.count, 0);
        bus.keycode = 8'h00;
        tick();

        // Reset during ACK aborts the handshake and clears the sticky flag.
        bus.keycode = 8'he1;
        tick();
        check("ack_strobe", bus.keystrobe, 1);
        reset = 1'b0;
        tick();
        check("ackrst_keystrobe", bus.keystrobe, 0);
        check("ackrst_count", bus.count, 0);
        check("ackrst_dir_out", bus.dir_out, 1);
        check("ackrst_overflow", bus.overflow, 0);
        bus.keycode = 8'h00;
        reset = 1'b1;
        tick();

        // Expiry: single entry dropped on the 8th frame tick.
        do_reset();
        press(8'hf3);
        check("exp_dir_out", bus.dir_out, 2);
        repeat (7) frame();
        check("exp_pending_7", bus.dir_pending, 1);
        frame();
        check("exp_pending_8", bus.dir_pending, 0);
        check("exp_dir_out_8", bus.dir_out, 1);

        // Full queue, consume and push together: no overwrite.
        do_reset();
        press(8'hf7);
        press(8'he1);
        press(8'hf3);
        press(8'he4);
        bus.keycode = 8'he1;
        bus.consume = 1'b1;
        tick();
        bus.consume = 1'b0;
        check("popush_count", bus.count, 4);
        check("popush_ovf", bus.overflow, 0);
        check("popush_head", bus.dir_out, 1);
        bus.keycode = 8'h00;
        tick();
        repeat (32) frame();
        check("popush_expired", bus.count, 0);
        check("popush_last_dir", bus.dir_out, 0);

        // count==1, pop plus push of the same direction: push accepted.
        press(8'hf3);
        bus.keycode = 8'hf3;
        bus.consume = 1'b1;
        tick();
        bus.consume = 1'b0;
        check("samedir_count", bus.count, 1);
        check("samedir_head", bus.dir_out, 2);
        bus.keycode = 8'h00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
